// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
package btn_pkg;

    localparam int unsigned DEBOUNCE_DEFAULT = 500000;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StArming    = 2'd1,
        StHeld      = 2'd2,
        StReleasing = 2'd3
    } btn_state_e;

    // Width able to hold 0..cycles.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Button bank bundle: raw levels in, conditioned pulses and levels out.
interface button_conditioner_if #(
    parameter int unsigned N_BTN = 3
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_level;

    modport master (
        output btn_raw,
        input  btn_pulse,
        input  btn_level
    );

    modport slave (
        input  btn_raw,
        output btn_pulse,
        output btn_level
    );
endinterface

// File: rtl/debounce_channel.sv
// One button: two-flop synchronizer, stability counter, FSM, registered pulse and level.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int unsigned CNT_W           = cnt_width(DEBOUNCE_DEFAULT)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             sync;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q;
    logic             level_q, level_d;
    logic             press_accept;
    logic             release_accept;

    assign sync = sync_q[1];

    // Reset lands in StReleasing so a button held through reset must be
    // seen released before a press can be accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= 2'b00;
            state_q <= StReleasing;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= press_accept;
            level_q <= level_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        press_accept   = 1'b0;
        release_accept = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sync) begin
                    state_d = StArming;
                    cnt_d   = CntOne;
                end
            end
            StArming: begin
                if (!sync) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d      = StHeld;
                    cnt_d        = '0;
                    press_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHeld: begin
                if (!sync) begin
                    state_d = StReleasing;
                    cnt_d   = CntOne;
                end
            end
            StReleasing: begin
                if (sync) begin
                    state_d = StHeld;
                    cnt_d   = '0;
                end else if (cnt_q == CntMax) begin
                    state_d        = StIdle;
                    cnt_d          = '0;
                    release_accept = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        level_d = level_q;
        if (press_accept) begin
            level_d = 1'b1;
        end else if (release_accept) begin
            level_d = 1'b0;
        end
    end

    assign pulse = pulse_q;
    assign level = level_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw push-buttons into single-cycle load pulses and clean levels.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int unsigned N_BTN           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    button_conditioner_if.slave  btn
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic [N_BTN-1:0] pulse_w;
    logic [N_BTN-1:0] level_w;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (btn.btn_raw[i]),
            .pulse (pulse_w[i]),
            .level (level_w[i])
        );
    end

    assign btn.btn_pulse = pulse_w;
    assign btn.btn_level = level_w;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES = 4.
module tb_button_conditioner;

    localparam int unsigned NB = 3;
    localparam int unsigned DC = 4;

    logic clk;
    logic reset;

    button_conditioner_if #(.N_BTN(NB)) bif ();

    button_conditioner #(
        .N_BTN           (NB),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif.slave)
    );

    int checks = 0;
    int errors = 0;
    int edge_no = 0;
    int pulse_cnt [NB];
    int pulse_edge [NB];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs sampled 1 time unit after it.
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            edge_no++;
            for (int i = 0; i < NB; i++) begin
                if (bif.btn_pulse[i] === 1'b1) begin
                    pulse_cnt[i]++;
                    pulse_edge[i] = edge_no;
                end
            end
        end
    endtask

    task automatic clear_stats();
        edge_no = 0;
        for (int i = 0; i < NB; i++) begin
            pulse_cnt[i]  = 0;
            pulse_edge[i] = 0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bif.btn_raw = '0;
        clear_stats();
        tick(2);
        check("reset_pulse", 32'(bif.btn_pulse), 32'h0);
        check("reset_level", 32'(bif.btn_level), 32'h0);
        reset = 1'b0;
        tick(6);

        // Clean press on channel 0
        clear_stats();
        bif.btn_raw = 3'b001;
        tick(5);
        check("clean_pulse_e5", 32'(bif.btn_pulse), 32'h0);
        check("clean_level_e5", 32'(bif.btn_level), 32'h0);
        tick();
        check("clean_pulse_e6", 32'(bif.btn_pulse), 32'h1);
        check("clean_level_e6", 32'(bif.btn_level), 32'h1);
        tick();
        check("clean_pulse_e7", 32'(bif.btn_pulse), 32'h0);
        tick(13);
        check("clean_cnt0", 32'(pulse_cnt[0]), 32'd1);
        check("clean_edge0", 32'(pulse_edge[0]), 32'd6);
        check("clean_others", 32'(pulse_cnt[1] + pulse_cnt[2]), 32'd0);
        check("clean_level_hold", 32'(bif.btn_level), 32'h1);

        // Clean release on channel 0
        clear_stats();
        bif.btn_raw = 3'b000;
        tick(5);
        check("rel_level_e5", 32'(bif.btn_level), 32'h1);
        tick();
        check("rel_level_e6", 32'(bif.btn_level), 32'h0);
        tick(4);

        // Press bounce on channel 1
        clear_stats();
        bif.btn_raw = 3'b010; tick();
        bif.btn_raw = 3'b000; tick();
        bif.btn_raw = 3'b010; tick();
        bif.btn_raw = 3'b000; tick();
        check("bounce_no_pulse", 32'(pulse_cnt[1]), 32'd0);
        edge_no = 0;
        bif.btn_raw = 3'b010;
        tick(20);
        check("bounce_cnt1", 32'(pulse_cnt[1]), 32'd1);
        check("bounce_edge1", 32'(pulse_edge[1]), 32'd6);
        check("bounce_level", 32'(bif.btn_level), 32'h2);

        // Release bounce on channel 2
        bif.btn_raw = 3'b100;
        tick(10);
        check("relb_level_set", 32'(bif.btn_level[2]), 32'h1);
        clear_stats();
        bif.btn_raw = 3'b000; tick(2);
        bif.btn_raw = 3'b100; tick();
        bif.btn_raw = 3'b000; tick(5);
        check("relb_level_e8", 32'(bif.btn_level[2]), 32'h1);
        tick();
        check("relb_level_e9", 32'(bif.btn_level[2]), 32'h0);
        check("relb_no_pulse", 32'(pulse_cnt[2]), 32'd0);
        tick(6);

        // Held through reset on channel 0
        bif.btn_raw = 3'b001;
        do_reset();
        clear_stats();
        tick(30);
        check("hold_rst_no_pulse", 32'(pulse_cnt[0]), 32'd0);
        check("hold_rst_level", 32'(bif.btn_level), 32'h0);
        bif.btn_raw = 3'b000;
        tick(10);
        clear_stats();
        bif.btn_raw = 3'b001;
        tick(10);
        check("hold_rst_repress_cnt", 32'(pulse_cnt[0]), 32'd1);
        check("hold_rst_repress_edge", 32'(pulse_edge[0]), 32'd6);
        check("hold_rst_repress_level", 32'(bif.btn_level), 32'h1);

        // Reset mid-count on channel 1 while channel 0 is held
        clear_stats();
        bif.btn_raw = 3'b011;
        tick(3);
        reset = 1'b1;
        #2;
        check("midrst_level_async", 32'(bif.btn_level), 32'h0);
        check("midrst_pulse_async", 32'(bif.btn_pulse), 32'h0);
        tick(2);
        reset = 1'b0;
        clear_stats();
        tick(30);
        check("midrst_no_pulse", 32'(pulse_cnt[0] + pulse_cnt[1]), 32'd0);
        check("midrst_level", 32'(bif.btn_level), 32'h0);
        bif.btn_raw = 3'b000;
        tick(10);
        clear_stats();
        bif.btn_raw = 3'b010;
        tick(10);
        check("midrst_repress_cnt", 32'(pulse_cnt[1]), 32'd1);
        check("midrst_repress_edge", 32'(pulse_edge[1]), 32'd6);

        // Simultaneous press on all channels
        bif.btn_raw = 3'b000;
        do_reset();
        tick(6);
        clear_stats();
        bif.btn_raw = 3'b111;
        tick(5);
        check("sim_pulse_e5", 32'(bif.btn_pulse), 32'h0);
        tick();
        check("sim_pulse_e6", 32'(bif.btn_pulse), 32'h7);
        check("sim_level_e6", 32'(bif.btn_level), 32'h7);
        tick();
        check("sim_pulse_e7", 32'(bif.btn_pulse), 32'h0);
        tick(100);
        for (int i = 0; i < NB; i++) begin
            check($sformatf("sim_cnt%0d", i), 32'(pulse_cnt[i]), 32'd1);
        end
        check("sim_level_hold", 32'(bif.btn_level), 32'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
